proximity_sensor: RTL and testbench
===================================

Name: proximity_sensor

Overview:
- Ultrasonic range-finder controller (HC-SR04 style) for the rover's collision guard.
- Periodically issues a trigger pulse, measures the width of the returned echo pulse in clock cycles, and asserts crash when the echo is shorter than a threshold (obstacle too close).
- Sits between the sensor pins and the drive/steering logic.

Parameters:
- TRIG_CYCLES, 500, trig high width in clocks (10 us at 50 MHz).
- PERIOD_CYCLES, 3000000, clocks from one trig rising edge to the next (60 ms); must exceed TRIG_CYCLES + ECHO_TIMEOUT_CYCLES + 4.
- CRASH_CYCLES, 58000, echo widths strictly below this count as close (about 20 cm).
- ECHO_TIMEOUT_CYCLES, 1500000, maximum wait for echo rise and maximum echo width.

Ports:
- clock  input  1  system clock, rising edge, 50 MHz nominal.
- reset_n  input  1  asynchronous, active-low reset.
- trig  output  1  sensor trigger pulse, registered.
- Echo  input  1  sensor echo, asynchronous to clock.
- crash  output  1  registered; 1 = obstacle closer than threshold.

Behaviour:
- One clock domain. reset_n is asynchronous active-low; while low: trig=0, crash=0, all counters 0, FSM in TRIG.
- Echo passes through a 2-flop synchronizer (echo_s). Edges are detected on echo_s against its previous value.
- Period counter free-runs 0..PERIOD_CYCLES-1 and wraps to 0. Wrap to 0 forces the FSM to TRIG from any state.
- TRIG state:
  - trig=1 for exactly TRIG_CYCLES clocks starting at the first edge after reset release or period wrap.
  - Then trig=0 and the FSM moves to WAIT_RISE with the width counter cleared.
- WAIT_RISE:
  - A rising edge of echo_s moves to MEASURE, with the width counter set to 1.
  - If the wait counter reaches ECHO_TIMEOUT_CYCLES, the reading is far: crash is updated to 0 and the FSM moves to HOLD.
  - An echo already high when trig falls is ignored until it falls and rises again.
- MEASURE:
  - Width counter increments each clock while echo_s=1.
  - On a falling edge of echo_s, the reading is close if width < CRASH_CYCLES and far otherwise. crash is updated on that same edge, then the FSM moves to HOLD.
  - Latency from the Echo pin falling to crash changing is 3 clock edges.
  - If the width reaches ECHO_TIMEOUT_CYCLES, the reading is far (crash=0), the counter saturates, and the FSM moves to HOLD.
- HOLD: idle with crash held until the period wraps. Extra echo pulses are ignored.
- crash changes only at a measurement decision, a timeout, or reset.
- The width counter is wide enough for ECHO_TIMEOUT_CYCLES and never wraps.
- Reset asserted mid-pulse or mid-measurement: outputs drop immediately, and the measurement is discarded.

Optional Feature:
- Macro PROX_FILTER_EN.
- Defined: crash rises only after 2 consecutive close readings and falls after 1 far reading. The consecutive-close count is cleared by reset and by any far or timeout reading.
- Undefined: each reading sets crash directly, as described in Behaviour.

Test Plan:
- Parameter overrides for all scenarios: TRIG_CYCLES=4, PERIOD_CYCLES=200, CRASH_CYCLES=20, ECHO_TIMEOUT_CYCLES=100. Clock period 20 ns. PROX_FILTER_EN undefined unless stated.
- Reset:
  - Stimulus: hold reset_n low 100 ns, then release.
  - Required: trig=0 and crash=0 during reset. trig high for exactly 4 clocks after release, then high again every 200 clocks.
- Far echo:
  - Stimulus: 100 ns after trig falls, drive Echo high for 1000 ns (50 clocks).
  - Required: crash remains 0.
- Close echo:
  - Stimulus: in the next period, Echo high for 100 ns (5 clocks) 100 ns after trig falls.
  - Required: crash=1 on the third clock edge after Echo falls; crash holds through the following trig.
- No echo:
  - Stimulus: starting with crash=1, Echo held low for a full period.
  - Required: crash returns to 0 at 100 clocks after trig falls.
- Stuck echo plus mid-measurement reset:
  - Stimulus: Echo held high 150 clocks.
  - Required: crash=0 at timeout, no second decision in that period.
  - Stimulus: pulse reset_n low during a later measurement.
  - Required: trig and crash go 0 immediately.
- PROX_FILTER_EN defined:
  - Stimulus: two consecutive 5-clock echoes.
  - Required: crash stays 0 after the first and becomes 1 after the second.
  - Stimulus: then one 50-clock echo.
  - Required: crash clears.

Source files
------------

// File: rtl/proximity_sensor.sv
// proximity_sensor: HC-SR04 style range-finder controller; crash=1 when the echo is shorter than CRASH_CYCLES.
// Optional macro PROX_FILTER_EN: crash rises only after two consecutive close readings.
module proximity_sensor #(
    parameter int TRIG_CYCLES         = 500,
    parameter int PERIOD_CYCLES       = 3000000,
    parameter int CRASH_CYCLES        = 58000,
    parameter int ECHO_TIMEOUT_CYCLES = 1500000
) (
    input  logic clock,
    input  logic reset_n,
    output logic trig,
    input  logic Echo,
    output logic crash
);

    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int CW = $clog2(ECHO_TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
    localparam logic [PW-1:0] TRIG_END     = PW'(TRIG_CYCLES);
    localparam logic [PW-1:0] PERIOD_ONE   = PW'(1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ECHO_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_MAX  = CW'(ECHO_TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [31:0]   CRASH_LIM    = 32'(CRASH_CYCLES);

    typedef enum logic [1:0] {
        ST_TRIG      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEASURE   = 2'd2,
        ST_HOLD      = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [PW-1:0]   period_cnt_r;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_next_s;
    logic            echo_meta_r;
    logic            echo_sync_r;
    logic            echo_prev_r;
    logic            rise_s;
    logic            fall_s;
    logic            wrap_s;
    logic            decide_s;
    logic            close_s;
    logic            trig_r;
    logic            crash_r;

    // Two-flop synchronizer for Echo plus the previous synchronized value for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            echo_meta_r <= 1'b0;
            echo_sync_r <= 1'b0;
            echo_prev_r <= 1'b0;
        end else begin
            echo_meta_r <= Echo;
            echo_sync_r <= echo_meta_r;
            echo_prev_r <= echo_sync_r;
        end
    end

    assign rise_s = echo_sync_r & ~echo_prev_r;
    assign fall_s = ~echo_sync_r & echo_prev_r;
    assign wrap_s = (period_cnt_r == PERIOD_LAST);

    // Free-running period counter; trig is high while the counter sits in the first TRIG_CYCLES slots
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt_r <= '0;
            trig_r       <= 1'b0;
        end else begin
            period_cnt_r <= wrap_s ? '0 : period_cnt_r + PERIOD_ONE;
            trig_r       <= (period_cnt_r < TRIG_END);
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_TRIG;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; the period wrap overrides every state
    always_comb begin
        state_next_s = state_r;
        if (wrap_s) begin
            state_next_s = ST_TRIG;
        end else begin
            case (state_r)
                ST_TRIG: begin
                    if (period_cnt_r == TRIG_END) begin
                        state_next_s = ST_WAIT_RISE;
                    end else begin
                        state_next_s = ST_TRIG;
                    end
                end
                ST_WAIT_RISE: begin
                    if (rise_s) begin
                        state_next_s = ST_MEASURE;
                    end else if (cnt_r >= TIMEOUT_LAST) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_WAIT_RISE;
                    end
                end
                ST_MEASURE: begin
                    if (fall_s || (cnt_r >= TIMEOUT_LAST)) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_MEASURE;
                    end
                end
                ST_HOLD: begin
                    state_next_s = ST_HOLD;
                end
                default: begin
                    state_next_s = ST_TRIG;
                end
            endcase
        end
    end

    // FSM outputs: shared wait/width counter and the close/far decision strobe
    always_comb begin
        cnt_next_s = cnt_r;
        decide_s   = 1'b0;
        close_s    = 1'b0;
        if (wrap_s) begin
            cnt_next_s = '0;
        end else begin
            case (state_r)
                ST_TRIG: begin
                    cnt_next_s = '0;
                end
                ST_WAIT_RISE: begin
                    if (rise_s) begin
                        cnt_next_s = CNT_ONE;
                    end else if (cnt_r >= TIMEOUT_LAST) begin
                        cnt_next_s = TIMEOUT_MAX;
                        decide_s   = 1'b1;
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    if (fall_s) begin
                        decide_s = 1'b1;
                        close_s  = (32'(cnt_r) < CRASH_LIM);
                    end else if (cnt_r >= TIMEOUT_LAST) begin
                        cnt_next_s = TIMEOUT_MAX;
                        decide_s   = 1'b1;
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    cnt_next_s = cnt_r;
                end
                default: begin
                    cnt_next_s = '0;
                end
            endcase
        end
    end

    // Wait/width counter register; saturates at the timeout value
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

`ifdef PROX_FILTER_EN
    logic close_seen_r;

    // crash rises on the second consecutive close reading and clears on any far reading
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crash_r      <= 1'b0;
            close_seen_r <= 1'b0;
        end else if (decide_s) begin
            if (close_s) begin
                crash_r      <= crash_r | close_seen_r;
                close_seen_r <= 1'b1;
            end else begin
                crash_r      <= 1'b0;
                close_seen_r <= 1'b0;
            end
        end else begin
            crash_r      <= crash_r;
            close_seen_r <= close_seen_r;
        end
    end
`else
    // crash follows each reading directly
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crash_r <= 1'b0;
        end else if (decide_s) begin
            crash_r <= close_s;
        end else begin
            crash_r <= crash_r;
        end
    end
`endif

    assign trig  = trig_r;
    assign crash = crash_r;

endmodule

// File: tb/tb_proximity_sensor.sv
// Bench for proximity_sensor: per-period stimulus table plus random periods, checked every clock
// against a timing/threshold model; ends with async reset during trig and during a measurement.
module tb_proximity_sensor;

    localparam int TRIG  = 4;
    localparam int PER   = 200;
    localparam int CRASH = 20;
    localparam int TMO   = 100;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic Echo    = 1'b0;
    logic trig;
    logic crash;

    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_crash   = 1'b0;
    int   close_run   = 0;

    typedef struct {
        int   d;          // clocks from trig falling edge to Echo pin rising
        int   n;          // Echo pin high width in clocks, 0 = no echo
        logic exp_plain;  // crash at end of period, default build
        logic exp_filt;   // crash at end of period, PROX_FILTER_EN build
    } vec_t;

    vec_t tbl[18];

    proximity_sensor #(
        .TRIG_CYCLES(TRIG),
        .PERIOD_CYCLES(PER),
        .CRASH_CYCLES(CRASH),
        .ECHO_TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .trig(trig),
        .Echo(Echo),
        .crash(crash)
    );

    always #10 clock = ~clock;

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Edge within the period (1-based) at which the reading is decided. Trig falls on edge TRIG+1.
    // The pin is seen as a synchronized rising edge two clocks after it is first sampled; a rise
    // seen before trig has fallen is ignored, leaving the wait to time out.
    function automatic int decision_edge(input int d, input int n);
        int f;
        f = TRIG + 1;
        if (n == 0 || d <= -2) return f + TMO;
        if (n >= TMO) return f + d + TMO + 1;
        return f + d + n + 2;
    endfunction

    function automatic logic reading_close(input int d, input int n);
        return (n > 0) && (d > -2) && (n < CRASH);
    endfunction

    task automatic apply_reading(input logic close);
`ifdef PROX_FILTER_EN
        if (close) begin
            close_run++;
            if (close_run >= 2) exp_crash = 1'b1;
        end else begin
            close_run = 0;
            exp_crash = 1'b0;
        end
`else
        exp_crash = close;
`endif
    endtask

    // Runs `stop` clocks of one period, driving Echo and checking trig/crash after every edge
    task automatic run_period(input int d, input int n, input int stop);
        int dec;
        dec = decision_edge(d, n);
        for (int j = 1; j <= stop; j++) begin
            @(negedge clock);
            if (j == dec) apply_reading(reading_close(d, n));
            check("trig", trig, (j <= TRIG) ? 1'b1 : 1'b0);
            check("crash", crash, exp_crash);
            Echo = (n > 0) && (j + 1 >= TRIG + 1 + d) && (j + 1 <= TRIG + d + n);
        end
    endtask

    // Called at a negedge: asserts reset between edges and expects outputs to drop at once
    task automatic reset_now(input string tag);
        reset_n = 1'b0;
        Echo    = 1'b0;
        #1;
        check({tag, "_trig"}, trig, 1'b0);
        check({tag, "_crash"}, crash, 1'b0);
        exp_crash = 1'b0;
        close_run = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{5,   50,  1'b0, 1'b0};
        tbl[1]  = '{5,   5,   1'b1, 1'b0};
        tbl[2]  = '{5,   5,   1'b1, 1'b1};
        tbl[3]  = '{5,   50,  1'b0, 1'b0};
        tbl[4]  = '{5,   5,   1'b1, 1'b0};
        tbl[5]  = '{5,   0,   1'b0, 1'b0};
        tbl[6]  = '{10,  19,  1'b1, 1'b0};
        tbl[7]  = '{10,  20,  1'b0, 1'b0};
        tbl[8]  = '{3,   1,   1'b1, 1'b0};
        tbl[9]  = '{60,  19,  1'b1, 1'b1};
        tbl[10] = '{5,   150, 1'b0, 1'b0};
        tbl[11] = '{20,  3,   1'b1, 1'b0};
        tbl[12] = '{-3,  20,  1'b0, 1'b0};
        tbl[13] = '{7,   99,  1'b0, 1'b0};
        tbl[14] = '{2,   12,  1'b1, 1'b0};
        tbl[15] = '{8,   100, 1'b0, 1'b0};
        tbl[16] = '{1,   2,   1'b1, 1'b0};
        tbl[17] = '{1,   2,   1'b1, 1'b1};

        repeat (4) begin
            @(negedge clock);
            check("reset_trig", trig, 1'b0);
            check("reset_crash", crash, 1'b0);
        end
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_period(tbl[i].d, tbl[i].n, PER);
`ifdef PROX_FILTER_EN
            check($sformatf("table[%0d]", i), crash, tbl[i].exp_filt);
`else
            check($sformatf("table[%0d]", i), crash, tbl[i].exp_plain);
`endif
        end

        for (int p = 0; p < 40; p++) begin
            int r;
            int d;
            int n;
            r = int'($urandom_range(0, 9));
            d = int'($urandom_range(1, 40));
            if (r == 0)     n = 0;
            else if (r < 6) n = int'($urandom_range(1, 25));
            else if (r < 8) n = int'($urandom_range(26, 99));
            else            n = int'($urandom_range(100, 150));
            run_period(d, n, PER);
        end

        // Reset while trig is high, with crash set
        run_period(5, 5, PER);
        run_period(5, 5, PER);
        check("pre_reset_crash", crash, 1'b1);
        run_period(5, 5, 3);
        reset_now("rst_in_trig");

        // Reset in the middle of a measurement, then a quiet period must keep crash low
        run_period(5, 5, PER);
        run_period(5, 5, PER);
        run_period(5, 30, 20);
        reset_now("rst_in_measure");
        run_period(5, 0, PER);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
